// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: N-master Wishbone request bundle plus the shared slave port.
// The master modport is the arbiter's view, the slave modport is the surrounding system's.
interface wb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 2,
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int SW = DW / 8;
    logic [NUM_MASTERS-1:0]    m_cyc_i, m_stb_i, m_we_i, m_ack_o, m_err_o, grant_o;
    logic [NUM_MASTERS*SW-1:0] m_sel_i;
    logic [NUM_MASTERS*AW-1:0] m_adr_i;
    logic [NUM_MASTERS*DW-1:0] m_dat_i;
    logic [DW-1:0]             m_dat_o, s_dat_o, s_dat_i;
    logic [AW-1:0]             s_adr_o;
    logic [SW-1:0]             s_sel_o;
    logic                      s_cyc_o, s_stb_o, s_we_o, s_ack_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        output m_ack_o, m_err_o, m_dat_o, grant_o,
               s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
        input  m_ack_o, m_err_o, m_dat_o, grant_o,
               s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: N-master Wishbone arbiter for the shared SDRAM port.
// Fixed-priority or round-robin grant held for a whole CYC tenure, with a stall timeout.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input logic             clk,
    input logic             rst_n,
    wb_rr_arbiter_if.master bus
);
    localparam int N  = NUM_MASTERS;
    localparam int SW = DW / 8;
    localparam int PW = N > 1 ? $clog2(N) : 1;

    typedef enum logic {IDLE, OWN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] own_q, own_d, ptr_q, ptr_d, win;
    logic [15:0]   cnt_q, cnt_d;
    logic          own, o_cyc, o_stb, stall, hit;
    int            k;

    // Scan downwards so the last match is the first requester at or after the base.
    always_comb begin
        win = '0;
        k = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (RR_MODE != 0 ? int'(ptr_q) : 0) + i;
            k = k >= N ? k - N : k;
            if (bus.m_cyc_i[PW'(k)]) win = PW'(k);
        end
    end

    assign own   = state_q == OWN;
    assign o_cyc = bus.m_cyc_i[own_q];
    assign o_stb = bus.m_stb_i[own_q];
    assign stall = own && o_cyc && o_stb && !bus.s_ack_i;
    assign hit   = TIMEOUT != 0 && stall && cnt_q == 16'(TIMEOUT - 1);

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        cnt_d   = '0;
        if (!own) begin
            state_d = |bus.m_cyc_i ? OWN : IDLE;
            own_d   = |bus.m_cyc_i ? win : own_q;
        end else if (!o_cyc || hit) begin
            state_d = IDLE;
            ptr_d   = RR_MODE == 0 ? ptr_q : own_q == PW'(N - 1) ? '0 : own_q + 1'b1;
        end else begin
            cnt_d = TIMEOUT != 0 && stall ? cnt_q + 1'b1 : '0;
        end
    end

    // Everything except the read-data broadcast is held at zero while reset is asserted.
    always_comb begin
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.grant_o = '0;
        bus.m_dat_o = bus.s_dat_i;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_sel_o = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        if (rst_n && own) begin
            bus.grant_o[own_q] = 1'b1;
            bus.m_ack_o[own_q] = bus.s_ack_i;
            bus.m_err_o[own_q] = hit;
            bus.s_cyc_o = o_cyc && !hit;
            bus.s_stb_o = o_stb && !hit;
            bus.s_we_o  = bus.m_we_i[own_q];
            bus.s_sel_o = bus.m_sel_i[own_q*SW +: SW];
            bus.s_adr_o = bus.m_adr_i[own_q*AW +: AW];
            bus.s_dat_o = bus.m_dat_i[own_q*DW +: DW];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            own_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: round-robin and fixed-priority arbiters driven by shared stimulus,
// checked every cycle against a tenure-level reference model.
module tb_wb_rr_arbiter;
    localparam int NM = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NM-1:0] cyc = '0, stb = '0, we = '0;
    logic [7:0]    sel = '0;
    logic [63:0]   adr = '0, wdat = '0;
    logic          ack = 1'b0;
    logic [15:0]   rdat = '0;

    logic [NM-1:0] gnt [2], m_ack [2], m_err [2];
    logic          s_cyc [2], s_stb [2], s_we [2];
    logic [1:0]    s_sel [2];
    logic [15:0]   s_adr [2], s_dat [2], m_dat [2];

    int own [2], ptr [2], cnt [2];
    logic errs [2], sts [2];
    logic [NM-1:0] snap_ack, snap_err;
    logic snap_scyc;
    int n_vec = 0, n_bad = 0;

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        wb_rr_arbiter_if #(.NUM_MASTERS(NM), .AW(16), .DW(16)) bus ();
        assign bus.m_cyc_i = cyc;
        assign bus.m_stb_i = stb;
        assign bus.m_we_i  = we;
        assign bus.m_sel_i = sel;
        assign bus.m_adr_i = adr;
        assign bus.m_dat_i = wdat;
        assign bus.s_ack_i = ack;
        assign bus.s_dat_i = rdat;
        assign gnt[d]   = bus.grant_o;
        assign m_ack[d] = bus.m_ack_o;
        assign m_err[d] = bus.m_err_o;
        assign m_dat[d] = bus.m_dat_o;
        assign s_cyc[d] = bus.s_cyc_o;
        assign s_stb[d] = bus.s_stb_o;
        assign s_we[d]  = bus.s_we_o;
        assign s_sel[d] = bus.s_sel_o;
        assign s_adr[d] = bus.s_adr_o;
        assign s_dat[d] = bus.s_dat_o;
        wb_rr_arbiter #(
            .NUM_MASTERS(NM), .AW(16), .DW(16), .RR_MODE(d == 0 ? 1 : 0), .TIMEOUT(TO)
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .bus(bus)
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input int base);
        for (int i = 0; i < NM; i++)
            if (cyc[(base + i) % NM]) return (base + i) % NM;
        return -1;
    endfunction

    // One clock: check outputs mid-cycle, then advance the model on the edge.
    task automatic step();
        #2;
        for (int d = 0; d < 2; d++) begin
            int oi;
            logic act, st, e_err;
            logic [NM-1:0] oh;
            oi    = own[d] < 0 ? 0 : own[d];
            act   = rst_n && own[d] >= 0;
            st    = act && cyc[oi] && stb[oi] && !ack;
            e_err = st && cnt[d] + 1 == TO;
            oh    = act ? NM'(1 << oi) : '0;
            chk($sformatf("grant%0d", d), 64'(gnt[d]), 64'(oh));
            chk($sformatf("m_ack%0d", d), 64'(m_ack[d]), ack ? 64'(oh) : 64'd0);
            chk($sformatf("m_err%0d", d), 64'(m_err[d]), e_err ? 64'(oh) : 64'd0);
            chk($sformatf("s_cyc%0d", d), 64'(s_cyc[d]), 64'(act && cyc[oi] && !e_err));
            chk($sformatf("s_stb%0d", d), 64'(s_stb[d]), 64'(act && stb[oi] && !e_err));
            chk($sformatf("m_dat%0d", d), 64'(m_dat[d]), 64'(rdat));
            if (act) begin
                chk($sformatf("s_adr%0d", d), 64'(s_adr[d]), 64'(adr[oi*16 +: 16]));
                chk($sformatf("s_dat%0d", d), 64'(s_dat[d]), 64'(wdat[oi*16 +: 16]));
                chk($sformatf("s_sel%0d", d), 64'(s_sel[d]), 64'(sel[oi*2 +: 2]));
                chk($sformatf("s_we%0d", d), 64'(s_we[d]), 64'(we[oi]));
            end
            errs[d] = e_err;
            sts[d]  = st;
        end
        snap_ack  = m_ack[0];
        snap_err  = m_err[0];
        snap_scyc = s_cyc[0];
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                own[d] = -1;
                ptr[d] = 0;
                cnt[d] = 0;
            end else if (own[d] < 0) begin
                own[d] = pick(d == 0 ? ptr[d] : 0);
                cnt[d] = 0;
            end else if (!cyc[own[d]] || errs[d]) begin
                if (d == 0) ptr[d] = (own[d] + 1) % NM;
                own[d] = -1;
                cnt[d] = 0;
            end else begin
                cnt[d] = sts[d] ? cnt[d] + 1 : 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        cyc = '0;
        stb = '0;
        ack = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int p;
        own = '{-1, -1};
        ptr = '{0, 0};
        cnt = '{0, 0};
        @(negedge clk);
        do_reset();

        // single master write to 0x10, slave acks on the second owned cycle
        cyc = 4'b0001; stb = 4'b0001; we = 4'b0001; adr = 64'h10;
        step();
        chk("single_grant", 64'(gnt[0]), 64'h1);
        chk("single_adr", 64'(s_adr[0]), 64'h10);
        step();
        ack = 1'b1;
        step();
        chk("single_ack", 64'(snap_ack), 64'h1);
        ack = 1'b0; cyc = '0; stb = '0;
        step();

        // round robin contention, one beat per tenure
        do_reset();
        cyc = '1; stb = '1; ack = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            chk("rr_grant", 64'(gnt[0]), 64'(1 << (t % NM)));
            step();
            cyc[t % NM] = 1'b0;
            step();
            chk("rr_idle", 64'(gnt[0]), 64'h0);
            cyc = '1;
        end

        // fixed priority: m1 keeps winning against m2
        do_reset();
        cyc = 4'b0110; stb = 4'b0110; ack = 1'b1;
        for (int t = 0; t < 3; t++) begin
            step();
            chk("fp_grant", 64'(gnt[1]), 64'h2);
            step();
            cyc = 4'b0100;
            step();
            cyc = 4'b0110;
        end

        // burst: m1 holds the bus over four beats while m0 waits
        do_reset();
        cyc = 4'b0010; stb = 4'b0010; ack = 1'b1;
        step();
        cyc = 4'b0011; stb = 4'b0011;
        for (int t = 0; t < 4; t++) begin
            step();
            chk("burst_hold", 64'(gnt[0]), 64'h2);
        end
        cyc = 4'b0001;
        step();
        chk("burst_idle", 64'(gnt[0]), 64'h0);
        step();
        chk("burst_m0", 64'(gnt[0]), 64'h1);

        // timeout with a slave that never acks
        do_reset();
        cyc = 4'b0011; stb = 4'b0011; ack = 1'b0;
        step();
        for (int i = 1; i <= TO; i++) begin
            step();
            chk("to_err", 64'(snap_err), i == TO ? 64'h1 : 64'h0);
        end
        chk("to_scyc", 64'(snap_scyc), 64'h0);
        step();
        chk("to_next", 64'(gnt[0]), 64'h2);

        // ack arriving on the timeout cycle wins
        do_reset();
        cyc = 4'b0001; stb = 4'b0001;
        step();
        for (int i = 1; i <= TO; i++) begin
            ack = i == TO;
            step();
        end
        chk("tack_ack", 64'(snap_ack), 64'h1);
        chk("tack_err", 64'(snap_err), 64'h0);
        ack = 1'b0;
        chk("tack_hold", 64'(gnt[0]), 64'h1);

        // reset in the middle of a tenure
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #2;
        chk("rst_grant", 64'(gnt[0]), 64'h0);
        chk("rst_scyc", 64'(s_cyc[0]), 64'h0);
        step();

        // randomized traffic with phases of varying slave responsiveness
        p = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) p = $urandom_range(3) == 0 ? 0 : $urandom_range(95);
            for (int m = 0; m < NM; m++)
                if ($urandom_range(7) == 0) cyc[m] = ~cyc[m];
            stb   = cyc & NM'($urandom);
            we    = NM'($urandom);
            sel   = 8'($urandom);
            adr   = {$urandom, $urandom};
            wdat  = {$urandom, $urandom};
            rdat  = 16'($urandom);
            ack   = $urandom_range(99) < p;
            rst_n = $urandom_range(299) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
